// File: rtl/tcdm_prio_sched.sv
// Starvation-aware priority scheduler driving a TCDM crossbar's per-bank rr_i inputs.
// Optional starvation statistics are enabled with the TCDM_PRIO_SCHED_STATS_EN macro.
module tcdm_prio_sched #(
   parameter int unsigned NumIn     = 4,
   parameter int unsigned NumOut    = 4,
   parameter int unsigned StarveThr = 8,
   localparam int unsigned IdxW     = $clog2(NumIn),
   localparam int unsigned AddW     = (NumOut > 1) ? $clog2(NumOut) : 1,
   localparam int unsigned CntW     = $clog2(StarveThr + 1)
) (
   input  logic                             clk_i,
   input  logic                             rst_i,
   input  logic [NumIn-1:0]                 req_i,
   input  logic [NumIn-1:0][AddW-1:0]       add_i,
   input  logic [NumIn-1:0]                 gnt_i,
`ifdef TCDM_PRIO_SCHED_STATS_EN
   input  logic                             stats_clr_i,
   output logic [NumIn-1:0][15:0]           starve_cnt_o,
`endif
   output logic [NumOut-1:0][IdxW-1:0]      rr_o,
   output logic [NumIn-1:0]                 starve_o
);

   typedef enum logic {ST_RR, ST_BOOST} state_e;

   logic [NumIn-1:0][CntW-1:0]  wait_cnt_q, wait_cnt_d;
   logic [NumIn-1:0]            starve_q, starve_d;
   state_e                      state_q [NumOut];
   state_e                      state_d [NumOut];
   logic [NumOut-1:0][IdxW-1:0] ptr_q, ptr_d;
   logic [NumOut-1:0][IdxW-1:0] boost_idx_q, boost_idx_d;
   logic [NumOut-1:0][IdxW-1:0] rr_q, rr_d;

   logic [NumOut-1:0]           starve_hit, gnt_hit;
   logic [NumOut-1:0][IdxW-1:0] starve_sel, gnt_sel;

   function automatic logic [IdxW-1:0] wrap_inc(input logic [IdxW-1:0] idx);
      if (idx == IdxW'(NumIn - 1)) return '0;
      return idx + IdxW'(1);
   endfunction

   // Per-requestor wait counters; starve flag registered from the next count.
   always_comb begin
      wait_cnt_d = wait_cnt_q;
      starve_d   = '0;
      for (int j = 0; j < NumIn; j++) begin
         if (req_i[j] && !gnt_i[j]) begin
            if (wait_cnt_q[j] != CntW'(StarveThr)) wait_cnt_d[j] = wait_cnt_q[j] + CntW'(1);
         end else begin
            wait_cnt_d[j] = '0;
         end
         starve_d[j] = (wait_cnt_d[j] == CntW'(StarveThr));
      end
   end

   // Lowest-index starving requestor and lowest-index granted requestor per target.
   always_comb begin
      starve_hit = '0;
      starve_sel = '0;
      gnt_hit    = '0;
      gnt_sel    = '0;
      for (int k = 0; k < NumOut; k++) begin
         for (int j = NumIn - 1; j >= 0; j--) begin
            if (req_i[j] && (add_i[j] == AddW'(k))) begin
               if (starve_q[j]) begin
                  starve_hit[k] = 1'b1;
                  starve_sel[k] = IdxW'(j);
               end
               if (gnt_i[j]) begin
                  gnt_hit[k] = 1'b1;
                  gnt_sel[k] = IdxW'(j);
               end
            end
         end
      end
   end

   // Per-target RR/BOOST next-state and pointer logic.
   always_comb begin
      state_d     = state_q;
      ptr_d       = ptr_q;
      boost_idx_d = boost_idx_q;
      rr_d        = '0;
      for (int k = 0; k < NumOut; k++) begin
         case (state_q[k])
            ST_RR: begin
               if (starve_hit[k]) begin
                  state_d[k]     = ST_BOOST;
                  boost_idx_d[k] = starve_sel[k];
               end else if (gnt_hit[k]) begin
                  ptr_d[k] = wrap_inc(gnt_sel[k]);
               end
            end
            ST_BOOST: begin
               if (req_i[boost_idx_q[k]] && gnt_i[boost_idx_q[k]] &&
                   (add_i[boost_idx_q[k]] == AddW'(k))) begin
                  state_d[k] = ST_RR;
                  ptr_d[k]   = wrap_inc(boost_idx_q[k]);
               end else if (!req_i[boost_idx_q[k]] ||
                            (add_i[boost_idx_q[k]] != AddW'(k))) begin
                  state_d[k] = ST_RR;
               end
            end
            default: state_d[k] = ST_RR;
         endcase
         rr_d[k] = (state_d[k] == ST_BOOST) ? boost_idx_d[k] : ptr_d[k];
      end
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         wait_cnt_q  <= '0;
         starve_q    <= '0;
         ptr_q       <= '0;
         boost_idx_q <= '0;
         rr_q        <= '0;
         for (int k = 0; k < NumOut; k++) state_q[k] <= ST_RR;
      end else begin
         wait_cnt_q  <= wait_cnt_d;
         starve_q    <= starve_d;
         ptr_q       <= ptr_d;
         boost_idx_q <= boost_idx_d;
         rr_q        <= rr_d;
         for (int k = 0; k < NumOut; k++) state_q[k] <= state_d[k];
      end
   end

   assign rr_o     = rr_q;
   assign starve_o = starve_q;

`ifdef TCDM_PRIO_SCHED_STATS_EN
   logic [NumIn-1:0][15:0] starve_cnt_q, starve_cnt_d;

   // Count rising edges of each starve flag; clear has priority.
   always_comb begin
      starve_cnt_d = starve_cnt_q;
      for (int j = 0; j < NumIn; j++) begin
         if (stats_clr_i) begin
            starve_cnt_d[j] = '0;
         end else if (starve_d[j] && !starve_q[j] && (starve_cnt_q[j] != 16'hFFFF)) begin
            starve_cnt_d[j] = starve_cnt_q[j] + 16'd1;
         end
      end
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) starve_cnt_q <= '0;
      else       starve_cnt_q <= starve_cnt_d;
   end

   assign starve_cnt_o = starve_cnt_q;
`endif

endmodule

// File: tb/tb_tcdm_prio_sched.sv
// Self-checking bench for tcdm_prio_sched (NumIn=4, NumOut=4, StarveThr=3):
// directed vector table, reset checks, and random traffic against a reference model.
module tb_tcdm_prio_sched;

   localparam int N   = 4;
   localparam int M   = 4;
   localparam int THR = 3;

   logic             clk = 1'b0;
   logic             rst;
   logic [N-1:0]     req, gnt;
   logic [N-1:0][1:0] add;
   logic [M-1:0][1:0] rr;
   logic [N-1:0]     starve;
   logic             stats_clr;
`ifdef TCDM_PRIO_SCHED_STATS_EN
   logic [N-1:0][15:0] scnt;
`endif

   int checks = 0;
   int errors = 0;

   tcdm_prio_sched #(.NumIn(N), .NumOut(M), .StarveThr(THR)) dut (
      .clk_i        (clk),
      .rst_i        (rst),
      .req_i        (req),
      .add_i        (add),
      .gnt_i        (gnt),
`ifdef TCDM_PRIO_SCHED_STATS_EN
      .stats_clr_i  (stats_clr),
      .starve_cnt_o (scnt),
`endif
      .rr_o         (rr),
      .starve_o     (starve)
   );

   always #5 clk = ~clk;

   // Reference model state
   int m_wc   [N];
   int m_ptr  [M];
   int m_bidx [M];
   bit m_boost[M];
   int m_scnt [N];

   task automatic model_reset();
      for (int j = 0; j < N; j++) begin m_wc[j] = 0; m_scnt[j] = 0; end
      for (int k = 0; k < M; k++) begin m_ptr[k] = 0; m_bidx[k] = 0; m_boost[k] = 0; end
   endtask

   task automatic model_step(input logic [3:0] rq, input logic [3:0] gn,
                             input logic [7:0] ad, input logic clr);
      int a[N];
      bit old_st[N];
      bit new_st;
      for (int j = 0; j < N; j++) begin
         a[j]      = int'(ad[2*j +: 2]);
         old_st[j] = (m_wc[j] == THR);
      end
      for (int k = 0; k < M; k++) begin
         if (!m_boost[k]) begin
            int s = -1;
            int g = -1;
            for (int j = 0; j < N; j++) begin
               if (s < 0 && old_st[j] && rq[j] && a[j] == k) s = j;
               if (g < 0 && rq[j] && gn[j] && a[j] == k) g = j;
            end
            if (s >= 0) begin
               m_boost[k] = 1;
               m_bidx[k]  = s;
            end else if (g >= 0) begin
               m_ptr[k] = (g + 1) % N;
            end
         end else begin
            int b = m_bidx[k];
            if (rq[b] && gn[b] && a[b] == k) begin
               m_boost[k] = 0;
               m_ptr[k]   = (b + 1) % N;
            end else if (!rq[b] || a[b] != k) begin
               m_boost[k] = 0;
            end
         end
      end
      for (int j = 0; j < N; j++) begin
         if (rq[j] && !gn[j]) m_wc[j] = (m_wc[j] + 1 > THR) ? THR : m_wc[j] + 1;
         else                 m_wc[j] = 0;
         new_st = (m_wc[j] == THR);
         if (clr)                                   m_scnt[j] = 0;
         else if (new_st && !old_st[j] && m_scnt[j] < 65535) m_scnt[j]++;
      end
   endtask

   function automatic logic [7:0] exp_rr();
      logic [7:0] r;
      for (int k = 0; k < M; k++) r[2*k +: 2] = 2'(m_boost[k] ? m_bidx[k] : m_ptr[k]);
      return r;
   endfunction

   function automatic logic [3:0] exp_st();
      logic [3:0] s;
      for (int j = 0; j < N; j++) s[j] = (m_wc[j] == THR);
      return s;
   endfunction

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // One clock cycle: drive, take the edge, sample 1 time unit later, advance the model.
   task automatic cyc(input logic [3:0] rq, input logic [3:0] gn,
                      input logic [7:0] ad, input logic clr);
      req = rq; gnt = gn; add = ad; stats_clr = clr;
      @(posedge clk);
      #1;
      model_step(rq, gn, ad, clr);
   endtask

   typedef struct {
      logic [3:0] req;
      logic [3:0] gnt;
      logic [7:0] add;
      logic [7:0] rr;
      logic [3:0] st;
   } vec_t;

   vec_t tbl [26];

   initial begin
      // Plain RR with wrap
      tbl[0]  = '{4'h4, 4'h4, 8'h10, 8'h0C, 4'h0};
      tbl[1]  = '{4'h8, 4'h8, 8'h40, 8'h00, 4'h0};
      // Starvation of j=1 on target 0, boost, then grant
      tbl[2]  = '{4'h2, 4'h0, 8'h00, 8'h00, 4'h0};
      tbl[3]  = '{4'h2, 4'h0, 8'h00, 8'h00, 4'h0};
      tbl[4]  = '{4'h2, 4'h0, 8'h00, 8'h00, 4'h2};
      tbl[5]  = '{4'h2, 4'h0, 8'h00, 8'h01, 4'h2};
      tbl[6]  = '{4'h2, 4'h2, 8'h00, 8'h02, 4'h0};
      // Boost abandon on target 2 (pre-boost ptr[2]=2)
      tbl[7]  = '{4'h2, 4'h2, 8'h08, 8'h22, 4'h0};
      tbl[8]  = '{4'h1, 4'h0, 8'h02, 8'h22, 4'h0};
      tbl[9]  = '{4'h1, 4'h0, 8'h02, 8'h22, 4'h0};
      tbl[10] = '{4'h1, 4'h0, 8'h02, 8'h22, 4'h1};
      tbl[11] = '{4'h1, 4'h0, 8'h02, 8'h02, 4'h1};
      tbl[12] = '{4'h1, 4'h0, 8'h03, 8'h22, 4'h1};
      tbl[13] = '{4'h0, 4'h0, 8'h00, 8'h22, 4'h0};
      // Grant coinciding with saturation: no starve, no boost
      tbl[14] = '{4'h8, 4'h0, 8'h40, 8'h22, 4'h0};
      tbl[15] = '{4'h8, 4'h0, 8'h40, 8'h22, 4'h0};
      tbl[16] = '{4'h8, 4'h8, 8'h40, 8'h22, 4'h0};
      tbl[17] = '{4'h0, 4'h0, 8'h00, 8'h22, 4'h0};
      // Two starving requestors (0 and 2) on target 1: lowest wins
      tbl[18] = '{4'h2, 4'h2, 8'h04, 8'h2A, 4'h0};
      tbl[19] = '{4'h5, 4'h0, 8'h11, 8'h2A, 4'h0};
      tbl[20] = '{4'h5, 4'h0, 8'h11, 8'h2A, 4'h0};
      tbl[21] = '{4'h5, 4'h0, 8'h11, 8'h2A, 4'h5};
      tbl[22] = '{4'h5, 4'h0, 8'h11, 8'h22, 4'h5};
      tbl[23] = '{4'h5, 4'h1, 8'h11, 8'h26, 4'h4};
      tbl[24] = '{4'h5, 4'h0, 8'h11, 8'h2A, 4'h4};
      tbl[25] = '{4'h0, 4'h0, 8'h00, 8'h26, 4'h0};

      rst = 1'b1; req = '0; gnt = '0; add = '0; stats_clr = 1'b0;
      model_reset();

      // Reset held with random inputs: outputs stay zero
      for (int i = 0; i < 6; i++) begin
         req = 4'($urandom); gnt = 4'($urandom); add = 8'($urandom);
         stats_clr = 1'($urandom);
         @(negedge clk);
         chk("reset rr_o", 64'(rr), 64'h0);
         chk("reset starve_o", 64'(starve), 64'h0);
`ifdef TCDM_PRIO_SCHED_STATS_EN
         chk("reset starve_cnt_o", 64'(scnt), 64'h0);
`endif
      end
      rst = 1'b0;
      stats_clr = 1'b0;

      // Directed vector table; entry 0 also shows the first edge after release updates state
      for (int i = 0; i < 26; i++) begin
         cyc(tbl[i].req, tbl[i].gnt, tbl[i].add, 1'b0);
         chk($sformatf("tbl[%0d] rr_o", i), 64'(rr), 64'(tbl[i].rr));
         chk($sformatf("tbl[%0d] starve_o", i), 64'(starve), 64'(tbl[i].st));
      end

      // Mid-operation asynchronous reset during an active boost
      for (int i = 0; i < 4; i++) cyc(4'h2, 4'h0, 8'h00, 1'b0);
      chk("pre-reset boost rr_o[0]", 64'(rr[0]), 64'h1);
      chk("pre-reset model rr_o", 64'(rr), 64'(exp_rr()));
      #3;
      rst = 1'b1;
      #1;
      chk("async reset rr_o", 64'(rr), 64'h0);
      chk("async reset starve_o", 64'(starve), 64'h0);
      @(posedge clk);
      #1;
      rst = 1'b0;
      model_reset();

`ifdef TCDM_PRIO_SCHED_STATS_EN
      // Two starvation episodes on j=2, then clear coinciding with a third onset
      for (int e = 0; e < 2; e++) begin
         for (int i = 0; i < 3; i++) cyc(4'h4, 4'h0, 8'h00, 1'b0);
         chk("stats episode starve_o[2]", 64'(starve[2]), 64'h1);
         cyc(4'h4, 4'h4, 8'h00, 1'b0);
      end
      chk("stats two episodes", 64'(scnt[2]), 64'd2);
      cyc(4'h4, 4'h0, 8'h00, 1'b0);
      cyc(4'h4, 4'h0, 8'h00, 1'b0);
      cyc(4'h4, 4'h0, 8'h00, 1'b1);
      chk("stats clr onset starve_o[2]", 64'(starve[2]), 64'h1);
      chk("stats clr wins", 64'(scnt[2]), 64'd0);
      cyc(4'h0, 4'h0, 8'h00, 1'b0);
`endif

      // Random traffic against the reference model; sparse grants provoke starvation
      for (int i = 0; i < 600; i++) begin
         logic [3:0] rq, gn;
         logic [7:0] ad;
         logic       clr;
         rq  = 4'($urandom);
         gn  = rq & 4'($urandom) & 4'($urandom);
         ad  = 8'($urandom);
         clr = ($urandom_range(0, 63) == 0);
         cyc(rq, gn, ad, clr);
         chk("rand rr_o", 64'(rr), 64'(exp_rr()));
         chk("rand starve_o", 64'(starve), 64'(exp_st()));
`ifdef TCDM_PRIO_SCHED_STATS_EN
         for (int j = 0; j < N; j++)
            chk($sformatf("rand starve_cnt_o[%0d]", j), 64'(scnt[j]), 64'(m_scnt[j]));
`endif
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
